// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the writeback-source selector.
package wb_mux_pkg;

  // Output buffer occupancy
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  // Default writeback source indices
  localparam int SRC_DM  = 0;
  localparam int SRC_ALU = 1;
  localparam int SRC_SUM = 2;

endpackage

// File: rtl/wb_mux_sel.sv
// Combinational N-way selector; out-of-range selects give zero and raise illegal.
module wb_mux_sel
  import wb_mux_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         src_sel,
  output logic [WIDTH-1:0]         sel_data,
  output logic                     illegal
);

  // Compare against every valid index so anything unmatched stays zero/illegal
  always_comb begin
    sel_data = '0;
    illegal  = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i)) begin
        sel_data = src_data[i*WIDTH +: WIDTH];
        illegal  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_mux_pipe.sv
// Writeback-source selector feeding a 2-entry skid buffer with valid/ready flow
// control, plus sticky/counting detection of illegal selects.
//
// state | meaning
// EMPTY | nothing buffered; out_valid=0, in_ready=1
// ONE   | main register holds the output word; in_ready=1
// TWO   | main and skid both full; in_ready=0
module wb_mux_pipe
  import wb_mux_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_sel,
  output logic [CNT_W-1:0]         ill_cnt,
  input  logic                     err_clr
);

  occ_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] sel_data;
  logic             illegal;
  logic             push, pop;

  wb_mux_sel #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_sel (
    .src_data (src_data),
    .src_sel  (src_sel),
    .sel_data (sel_data),
    .illegal  (illegal)
  );

  // Handshake flags are decoded from registered state only, so reset drops them at once
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign err_sel   = err_q;
  assign ill_cnt   = cnt_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy next-state and data movement between main and skid registers
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = sel_data;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
          skid_d  = sel_data;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          main_d  = sel_data;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Error tracking; an illegal push in the same cycle as err_clr takes priority
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
    if (push && illegal) begin
      err_d = 1'b1;
      if (err_clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, data and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_mux_pipe.sv
// Self-checking bench for wb_mux_pipe: directed steps plus a random phase, all
// compared against a queue-based model of a 2-deep FIFO with error counting.
module tb_wb_mux_pipe;
  import wb_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] src_data;
  logic [1:0]  src_sel;
  logic        in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic        err_sel, err_clr;
  logic [7:0]  ill_cnt;

  logic [63:0] src_data4;
  logic [1:0]  src_sel4;
  logic        in_valid4, in_ready4;
  logic [15:0] out_data4;
  logic        out_valid4, out_ready4;
  logic        err_sel4, err_clr4;
  logic [7:0]  ill_cnt4;

  int checks = 0;
  int errors = 0;

  logic [31:0] src [3];
  logic [31:0] mq [$];
  logic [31:0] m_last;
  logic        m_err;
  int          m_cnt;

  always #5 clk = ~clk;

  wb_mux_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_sel(src_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel),
    .ill_cnt(ill_cnt), .err_clr(err_clr)
  );

  wb_mux_pipe #(.WIDTH(16), .NUM_SRC(4), .SEL_W(2), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .src_data(src_data4), .src_sel(src_sel4),
    .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .err_sel(err_sel4),
    .ill_cnt(ill_cnt4), .err_clr(err_clr4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, out_valid, (mq.size() > 0));
    chk({tag, ".in_ready"},  in_ready,  (mq.size() < 2));
    chk({tag, ".out_data"},  out_data,  m_last);
    chk({tag, ".err_sel"},   err_sel,   m_err);
    chk({tag, ".ill_cnt"},   ill_cnt,   m_cnt[7:0]);
  endtask

  // One clock of stimulus; the model advances with the same push/pop rules a
  // 2-deep FIFO would follow, then all outputs are compared 1 time unit later.
  task automatic step(input string tag, input logic v, input logic [1:0] s,
                      input logic r, input logic c);
    logic do_push, do_pop;
    in_valid  = v;
    src_sel   = s;
    out_ready = r;
    err_clr   = c;
    src_data  = {src[2], src[1], src[0]};
    do_push   = v && (mq.size() < 2);
    do_pop    = r && (mq.size() > 0);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back((s < 2'd3) ? src[s] : 32'h0);
    if (c) begin
      m_err = 1'b0;
      m_cnt = 0;
    end
    if (do_push && s == 2'd3) begin
      m_err = 1'b1;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
    if (mq.size() > 0) m_last = mq[0];
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; src_sel = 0; out_ready = 0; err_clr = 0; src_data = '0;
    in_valid4 = 0; src_sel4 = 0; out_ready4 = 1; err_clr4 = 0; src_data4 = '0;
    model_reset();
    #3;
    check_all("reset");
    #10 rst_n = 1'b1;

    // 1: streaming through all default sources
    src[SRC_DM] = 32'h1111_1111; src[SRC_ALU] = 32'h2222_2222; src[SRC_SUM] = 32'h3333_3333;
    step("stream0", 1, 2'd0, 1, 0);
    chk("stream0.const", out_data, 32'h1111_1111);
    step("stream1", 1, 2'd1, 1, 0);
    chk("stream1.const", out_data, 32'h2222_2222);
    step("stream2", 1, 2'd2, 1, 0);
    chk("stream2.const", out_data, 32'h3333_3333);
    step("drain", 0, 2'd0, 1, 0);
    chk("drain.hold", out_data, 32'h3333_3333);

    // 2: backpressure fills both entries, third push is refused
    step("bp1", 1, 2'd1, 0, 0);
    step("bp2", 1, 2'd2, 0, 0);
    chk("bp2.full", in_ready, 1'b0);
    step("bp3", 1, 2'd0, 0, 0);
    chk("bp3.hold", out_data, 32'h2222_2222);
    step("bp_rel1", 0, 2'd0, 1, 0);
    chk("bp_rel1.const", out_data, 32'h3333_3333);
    step("bp_rel2", 0, 2'd0, 1, 0);
    chk("bp_rel2.empty", out_valid, 1'b0);

    // 3: illegal select, and illegal select without in_valid
    step("ill1", 1, 2'd3, 1, 0);
    chk("ill1.cnt", ill_cnt, 8'd1);
    step("ill_novalid", 0, 2'd3, 1, 0);
    chk("ill_novalid.cnt", ill_cnt, 8'd1);

    // 4: saturation, clear, and clear racing an illegal push
    for (int i = 0; i < 300; i++) step("sat", 1, 2'd3, 1, 0);
    chk("sat.cnt", ill_cnt, 8'd255);
    step("clr", 0, 2'd0, 1, 1);
    chk("clr.cnt", ill_cnt, 8'd0);
    step("clr_set", 1, 2'd3, 1, 1);
    chk("clr_set.err", err_sel, 1'b1);
    chk("clr_set.cnt", ill_cnt, 8'd1);
    step("clr2", 0, 2'd0, 1, 1);

    // 5: asynchronous reset between edges while full
    src[0] = 32'hAAAA_0001; src[1] = 32'hAAAA_0002;
    step("pre_rst1", 1, 2'd0, 0, 0);
    step("pre_rst2", 1, 2'd1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async.out_valid", out_valid, 1'b0);
    chk("async.out_data", out_data, 32'h0);
    chk("async.in_ready", in_ready, 1'b1);
    #1 rst_n = 1'b1;
    step("post_rst", 0, 2'd0, 1, 0);
    chk("post_rst.no_emit", out_valid, 1'b0);

    // 6: power-of-two source count, index 3 is legal
    src_data4 = {16'hBEEF, 16'h3333, 16'h2222, 16'h1111};
    src_sel4  = 2'd3;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    chk("gen.out_data", out_data4, 16'hBEEF);
    chk("gen.out_valid", out_valid4, 1'b1);
    chk("gen.err_sel", err_sel4, 1'b0);
    chk("gen.ill_cnt", ill_cnt4, 8'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) src[k] = $urandom;
      step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
